// File: rtl/asteroids_pkg.sv
// -----------------------------------------------------------------------------
// asteroids_pkg
// Shared types and constants for the heading/trigonometry path.
//   sincos_t     : signed Q1.17 sine/cosine sample (18 bits)
//   SINCOS_ONE   : full-scale positive value (+1.0 is clipped to 131071)
//   quarter_sin  : T[k] = round(SINCOS_ONE * sin(pi/2 * k / q)), k = 0..q.
//                  Elaboration-time only. It is used to build ROM constants
//                  and is never instantiated as logic.
// -----------------------------------------------------------------------------
package asteroids_pkg;

   typedef logic signed [17:0] sincos_t;

   localparam int SINCOS_ONE = 131071;

   // Taylor series in reals. The argument is at most pi/2, so 12 terms
   // converge far below one LSB of the Q1.17 result.
   function automatic int quarter_sin(input int k, input int q);
      real x;
      real term;
      real sum;
      int  res;
      x    = 1.5707963267948966 * k / q;
      term = x;
      sum  = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / ((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      res = $rtoi(SINCOS_ONE * sum + 0.5);
      if (res > SINCOS_ONE) res = SINCOS_ONE;
      if (res < 0)          res = 0;
      return res;
   endfunction

endpackage

// File: rtl/sincos_quarter_rom.sv
// -----------------------------------------------------------------------------
// sincos_quarter_rom
// Two-stage registered dual sine/cosine lookup built on a quarter-wave table.
// Stage 1 registers the quadrant and the in-quadrant index of the angle. The
// cosine quadrant is the sine quadrant + 1, because cos(a) = sin(a + quarter)
// and the index stays the same. Stage 2 registers the signed table lookup.
// The result appears exactly two clock cycles after the angle input changes.
// If the angle input does not change, the outputs do not change.
//
// Parameters:
//   ANGLE_STEPS : angle codes per full turn (multiple of 4)
// Ports:
//   clk     in   clock
//   reset   in   asynchronous, active-high reset (outputs = angle 0 values)
//   angle   in   heading index, 0..ANGLE_STEPS-1
//   sin_val out  registered sin(angle), Q1.17
//   cos_val out  registered cos(angle), Q1.17
// -----------------------------------------------------------------------------
module sincos_quarter_rom
   import asteroids_pkg::*;
#(
   parameter int ANGLE_STEPS = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [$clog2(ANGLE_STEPS)-1:0] angle,
   output sincos_t                        sin_val,
   output sincos_t                        cos_val
);

   localparam int Q  = ANGLE_STEPS / 4;
   localparam int IW = $clog2(Q + 1);

   // Quarter-wave table, T[0..Q], fixed at elaboration.
   sincos_t tab [0:Q];

   for (genvar k = 0; k <= Q; k++) begin : g_tab
      localparam int TV = quarter_sin(k, Q);
      assign tab[k] = sincos_t'(TV);
   end

   // Stage 1 registers
   logic [1:0]    sin_quad;
   logic [1:0]    cos_quad;
   logic [IW-1:0] idx;

   // Stage 2 inputs
   logic [IW-1:0] mirror;
   sincos_t       sin_next;
   sincos_t       cos_next;

   // Quadrant fold: even quadrants read the table forward, odd quadrants
   // read it mirrored. Quadrants 2 and 3 are negated.
   function automatic sincos_t fold(input logic [1:0] quad,
                                    input sincos_t    t_fwd,
                                    input sincos_t    t_mir);
      sincos_t v;
      case (quad)
         2'd0:    v = t_fwd;
         2'd1:    v = t_mir;
         2'd2:    v = -t_fwd;
         default: v = -t_mir;
      endcase
      return v;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sin_quad <= 2'd0;
         cos_quad <= 2'd1;
         idx      <= '0;
      end else begin
         sin_quad <= 2'(angle / Q);
         cos_quad <= 2'(angle / Q) + 2'd1;
         idx      <= IW'(angle % Q);
      end
   end

   always_comb begin
      mirror   = IW'(Q) - idx;
      sin_next = fold(sin_quad, tab[idx], tab[mirror]);
      cos_next = fold(cos_quad, tab[idx], tab[mirror]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sin_val <= '0;
         cos_val <= sincos_t'(SINCOS_ONE);
      end else begin
         sin_val <= sin_next;
         cos_val <= cos_next;
      end
   end

endmodule

// File: rtl/ship_heading_unit.sv
// -----------------------------------------------------------------------------
// ship_heading_unit
// Source side of the heading/timing interface that the torpedo units and the
// ship sprite use.
//   - vsync_raw rising edge -> one-cycle vsync pulse
//   - heading index stepped from the rotate buttons, evaluated on vsync
//   - registered signed Q1.17 sin/cos of the heading, 2-cycle latency
//   - shared sprite animation base offset (frame * FRAME_SIZE)
//
// Optional feature macro: ROT_ACCEL_EN
//   When defined, after 8 consecutive heading steps in the same direction the
//   rotation advances every frame. Releasing, reversing or pressing both
//   buttons clears the streak.
//
// Parameters:
//   ANGLE_STEPS (64) headings per turn, multiple of 4
//   ROT_DIV     (2)  frames per heading step while a button is held
//   ANIM_FRAMES (3)  animation frames
//   FRAME_SIZE  (90) sprite words per frame
//   ANIM_DIV    (4)  frames per animation advance
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   vsync_raw    in   VGA vsync level, synchronous to clk
//   rot_left     in   rotate counter-clockwise (synchronised level)
//   rot_right    in   rotate clockwise (synchronised level)
//   vsync        out  1-cycle pulse, 1 cycle after the vsync_raw rising edge
//   angle        out  heading index
//   sin_val      out  sin(angle), Q1.17
//   cos_val      out  cos(angle), Q1.17
//   sincos_valid out  sin/cos match the current angle
//   anim_base    out  sprite address offset of the current animation frame
//
// Consumer contract: sin_val/cos_val change only 2 cycles after an angle
// change, and sincos_valid is low for exactly those 2 cycles. At all other
// times the outputs are stable and may be sampled freely.
// -----------------------------------------------------------------------------
module ship_heading_unit
   import asteroids_pkg::*;
#(
   parameter int ANGLE_STEPS = 64,
   parameter int ROT_DIV     = 2,
   parameter int ANIM_FRAMES = 3,
   parameter int FRAME_SIZE  = 90,
   parameter int ANIM_DIV    = 4
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        vsync_raw,
   input  logic                                        rot_left,
   input  logic                                        rot_right,
   output logic                                        vsync,
   output logic [$clog2(ANGLE_STEPS)-1:0]              angle,
   output sincos_t                                     sin_val,
   output sincos_t                                     cos_val,
   output logic                                        sincos_valid,
   output logic [$clog2(ANIM_FRAMES*FRAME_SIZE)-1:0]   anim_base
);

   localparam int AW = $clog2(ANGLE_STEPS);
   localparam int BW = $clog2(ANIM_FRAMES * FRAME_SIZE);
   localparam int RW = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
   localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   localparam logic [AW-1:0] ANGLE_MAX = AW'(ANGLE_STEPS - 1);

   // ---------------------------------------------------------------------
   // vsync edge detect. The delay flop resets high, so a vsync_raw that is
   // already high when reset is released does not produce a pulse.
   // ---------------------------------------------------------------------
   logic vsync_raw_d1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_raw_d1 <= 1'b1;
         vsync        <= 1'b0;
      end else begin
         vsync_raw_d1 <= vsync_raw;
         vsync        <= vsync_raw & ~vsync_raw_d1;
      end
   end

   // ---------------------------------------------------------------------
   // Rotation
   // ---------------------------------------------------------------------
   logic [RW-1:0] rot_cnt;
   logic          one_btn;
   logic          accel;
   logic          step;
   logic [AW-1:0] angle_next;

`ifdef ROT_ACCEL_EN
   logic [3:0] streak;      // saturating count of same-direction steps
   logic       last_right;  // direction of the last step (1 = clockwise)
`endif

   always_comb begin
      one_btn = rot_left ^ rot_right;
`ifdef ROT_ACCEL_EN
      accel   = (streak == 4'd8) && (rot_right == last_right);
`else
      accel   = 1'b0;
`endif
      step    = vsync && one_btn && ((rot_cnt == RW'(ROT_DIV - 1)) || accel);
      if (rot_right)
         angle_next = (angle == ANGLE_MAX) ? '0 : angle + AW'(1);
      else
         angle_next = (angle == '0) ? ANGLE_MAX : angle - AW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rot_cnt <= '0;
         angle   <= '0;
      end else if (vsync) begin
         if (one_btn) begin
            if (step) begin
               rot_cnt <= '0;
               angle   <= angle_next;
            end else begin
               rot_cnt <= rot_cnt + RW'(1);
            end
         end else begin
            rot_cnt <= '0;
         end
      end
   end

`ifdef ROT_ACCEL_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         streak     <= '0;
         last_right <= 1'b0;
      end else if (vsync) begin
         if (!one_btn) begin
            streak <= '0;
         end else if (streak != 4'd0 && rot_right != last_right) begin
            // Reversal: the streak restarts from zero at normal pacing.
            streak <= '0;
         end else if (step) begin
            last_right <= rot_right;
            if (streak != 4'd8) streak <= streak + 4'd1;
         end
      end
   end
`endif

   // ---------------------------------------------------------------------
   // sin/cos pipeline and validity
   // step_d1 tracks an angle change through the first pipeline stage, so
   // valid is low from the angle update until the new values appear.
   // ---------------------------------------------------------------------
   logic step_d1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_d1      <= 1'b0;
         sincos_valid <= 1'b1;
      end else begin
         step_d1      <= step;
         sincos_valid <= ~(step | step_d1);
      end
   end

   sincos_quarter_rom #(
      .ANGLE_STEPS (ANGLE_STEPS)
   ) u_rom (
      .clk     (clk),
      .reset   (reset),
      .angle   (angle),
      .sin_val (sin_val),
      .cos_val (cos_val)
   );

   // ---------------------------------------------------------------------
   // Animation: anim_base accumulates FRAME_SIZE per frame advance instead
   // of multiplying.
   // ---------------------------------------------------------------------
   logic [CW-1:0] anim_cnt;
   logic [FW-1:0] frame;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anim_cnt  <= '0;
         frame     <= '0;
         anim_base <= '0;
      end else if (vsync) begin
         if (anim_cnt == CW'(ANIM_DIV - 1)) begin
            anim_cnt <= '0;
            if (frame == FW'(ANIM_FRAMES - 1)) begin
               frame     <= '0;
               anim_base <= '0;
            end else begin
               frame     <= frame + FW'(1);
               anim_base <= anim_base + BW'(FRAME_SIZE);
            end
         end else begin
            anim_cnt <= anim_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ship_heading_unit.sv
// -----------------------------------------------------------------------------
// tb_ship_heading_unit
// Directed bench for ship_heading_unit with default parameters. One table row
// is a button pattern held for N frames, followed by the expected heading,
// sin/cos and anim_base. Hand-written sequences cover reset release,
// cycle-exact pipeline timing and a reset in the middle of the pipeline.
// -----------------------------------------------------------------------------
module tb_ship_heading_unit;
   import asteroids_pkg::*;

   logic       clk;
   logic       reset;
   logic       vsync_raw;
   logic       rot_left;
   logic       rot_right;
   logic       vsync;
   logic [5:0] angle;
   sincos_t    sin_val;
   sincos_t    cos_val;
   logic       sincos_valid;
   logic [8:0] anim_base;

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   ship_heading_unit dut (
      .clk          (clk),
      .reset        (reset),
      .vsync_raw    (vsync_raw),
      .rot_left     (rot_left),
      .rot_right    (rot_right),
      .vsync        (vsync),
      .angle        (angle),
      .sin_val      (sin_val),
      .cos_val      (cos_val),
      .sincos_valid (sincos_valid),
      .anim_base    (anim_base)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, act=running exp=finished");
      $fatal(1, "watchdog");
   end

   // Count vsync pulses, sampled away from the active edge.
   always @(negedge clk) if (vsync) pulses++;

   // ---------------- checking ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input int a, input int s,
                                input int c, input int ab);
      check({tag, " angle"},     int'(angle),     a);
      check({tag, " sin"},       int'(sin_val),   s);
      check({tag, " cos"},       int'(cos_val),   c);
      check({tag, " anim_base"}, int'(anim_base), ab);
      check({tag, " valid"},     int'(sincos_valid), 1);
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      reset     = 1'b1;
      vsync_raw = 1'b1;
      rot_left  = 1'b0;
      rot_right = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // One frame: raw low 4 cycles, then a rising edge and 6 cycles high,
   // long enough for the vsync pulse, angle update and the sin/cos pipeline.
   task automatic do_frame();
      vsync_raw = 1'b0;
      repeat (4) @(posedge clk);
      #1 vsync_raw = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic l;
      logic r;
      int   reps;
      int   exp_angle;
      int   exp_sin;
      int   exp_cos;
      int   exp_anim;
   } vec_t;

   vec_t vecs [0:17];

   task automatic run_rows(input int first, input int last);
      int p0;
      for (int i = first; i <= last; i++) begin
         rot_left  = vecs[i].l;
         rot_right = vecs[i].r;
         p0 = pulses;
         repeat (vecs[i].reps) do_frame();
         @(negedge clk);
         check($sformatf("row%0d pulses", i), pulses - p0, vecs[i].reps);
         check_outputs($sformatf("row%0d", i), vecs[i].exp_angle,
                       vecs[i].exp_sin, vecs[i].exp_cos, vecs[i].exp_anim);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      // Expected values after the given number of frames since reset.
      // T[1]=12847 T[2]=25571 T[14]=128553 T[15]=130440 T[16]=131071
      vecs[0]  = '{1'b0, 1'b1,  1,  0,       0, 131071,   0};
      vecs[1]  = '{1'b0, 1'b1,  1,  1,   12847, 130440,   0};
      vecs[2]  = '{1'b0, 1'b1,  1,  1,   12847, 130440,   0};
      // frame 4 is the hand-written cycle-exact step to angle 2
      vecs[3]  = '{1'b1, 1'b0,  1,  2,   25571, 128553,  90};
      vecs[4]  = '{1'b1, 1'b0,  1,  1,   12847, 130440,  90};
      vecs[5]  = '{1'b1, 1'b0,  1,  1,   12847, 130440,  90};
      vecs[6]  = '{1'b1, 1'b0,  1,  0,       0, 131071, 180};
      vecs[7]  = '{1'b1, 1'b0,  1,  0,       0, 131071, 180};
      vecs[8]  = '{1'b1, 1'b0,  1, 63,  -12847, 130440, 180};
      vecs[9]  = '{1'b1, 1'b0,  1, 63,  -12847, 130440, 180};
      vecs[10] = '{1'b1, 1'b1, 10, 63,  -12847, 130440, 180};
      vecs[11] = '{1'b1, 1'b0,  1, 63,  -12847, 130440, 180};
      vecs[12] = '{1'b1, 1'b0,  1, 62,  -25571, 128553, 180};
      vecs[13] = '{1'b1, 1'b0, 28, 48, -131071,      0,   0};
      vecs[14] = '{1'b0, 1'b0,  3, 48, -131071,      0,  90};
      vecs[15] = '{1'b0, 1'b1, 30, 63,  -12847, 130440,   0};
      vecs[16] = '{1'b0, 1'b1,  2,  0,       0, 131071,   0};
      vecs[17] = '{1'b0, 1'b1, 32, 16,  131071,      0, 180};

      // ---- reset release with vsync_raw high: no pulse ----
      apply_reset();
      repeat (4) begin
         @(negedge clk);
         check("reset vsync", int'(vsync), 0);
      end
      check_outputs("reset", 0, 0, 131071, 0);
      check("reset pulses", pulses, 0);
      @(posedge clk); #1;

`ifndef ROT_ACCEL_EN
      run_rows(0, 2);

      // ---- frame 4: cycle-exact step 1 -> 2 ----
      vsync_raw = 1'b0;
      repeat (4) @(posedge clk);
      #1 vsync_raw = 1'b1;
      @(negedge clk);
      check("f4 pre vsync", int'(vsync), 0);
      @(negedge clk);
      check("f4 vsync", int'(vsync), 1);
      check("f4 angle hold", int'(angle), 1);
      check("f4 valid before", int'(sincos_valid), 1);
      @(negedge clk);
      check("f4 vsync width", int'(vsync), 0);
      check("f4 angle new", int'(angle), 2);
      check("f4 valid c0", int'(sincos_valid), 0);
      check("f4 sin old c0", int'(sin_val), 12847);
      check("f4 anim", int'(anim_base), 90);
      @(negedge clk);
      check("f4 valid c1", int'(sincos_valid), 0);
      check("f4 sin old c1", int'(sin_val), 12847);
      check("f4 cos old c1", int'(cos_val), 130440);
      @(negedge clk);
      check("f4 valid c2", int'(sincos_valid), 1);
      check("f4 sin new", int'(sin_val), 25571);
      check("f4 cos new", int'(cos_val), 128553);
      @(posedge clk); #1;

      run_rows(3, 17);
`endif

      // ---- reset in the middle of the pipeline ----
      rot_left  = 1'b0;
      rot_right = 1'b1;
      apply_reset();
      rot_right = 1'b1;
      do_frame();                 // rot_cnt -> 1
      vsync_raw = 1'b0;
      repeat (4) @(posedge clk);
      #1 vsync_raw = 1'b1;
      repeat (3) @(negedge clk);  // angle has just changed to 1
      check("mid angle moved", int'(angle), 1);
      check("mid valid low", int'(sincos_valid), 0);
      reset = 1'b1;
      #1;
      check("mid rst angle", int'(angle), 0);
      check("mid rst sin", int'(sin_val), 0);
      check("mid rst cos", int'(cos_val), 131071);
      check("mid rst valid", int'(sincos_valid), 1);
      check("mid rst vsync", int'(vsync), 0);
      @(posedge clk); #1 reset = 1'b0;
      do_frame();
      do_frame();
      @(negedge clk);
      check_outputs("restart", 1, 12847, 130440, 0);
      @(posedge clk); #1;

`ifdef ROT_ACCEL_EN
      // ---- accelerated rotation ----
      apply_reset();
      rot_right = 1'b1;
      for (int f = 1; f <= 30; f++) begin
         do_frame();
         if (f == 16) begin
            @(negedge clk);
            check("accel f16 angle", int'(angle), 8);
            @(posedge clk); #1;
         end
      end
      @(negedge clk);
      check("accel f30 angle", int'(angle), 22);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
